// File: rtl/bist_seq.sv
// Self-test sequencer: drives LFSR-derived operand vectors into the flight-equation unit and checks its results.
// Each vector/equation pair is held SETTLE cycles; run results are reported with a one-cycle bist_done pulse.
module bist_seq #(
   parameter int unsigned NUM_VEC      = 4,
   parameter int unsigned SETTLE       = 4,
   parameter logic [31:0] LFSR_SEED    = 32'h05040303,
   parameter bit          STOP_ON_FAIL = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_bist,
   input  logic        abort,
   input  logic [15:0] result_a,
   input  logic [15:0] result_b,
   output logic [7:0]  x1_test,
   output logic [7:0]  x2_test,
   output logic [7:0]  v_test,
   output logic [7:0]  t_test,
   output logic [7:0]  c_test,
   output logic        sel_eq_test,
   output logic        bist_active,
   output logic        bist_done,
   output logic        bist_pass,
   output logic [7:0]  fail_cnt,
   output logic [7:0]  first_fail_idx,
   output logic        first_fail_eq
);
   localparam int unsigned CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);
   localparam logic [7:0]  VEC_LAST = 8'(NUM_VEC - 1);
   localparam logic [31:0] SEED     = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;
   localparam logic [31:0] POLY     = 32'h80200003;

   typedef enum logic [1:0] {IDLE, APPLY_A, APPLY_B, DONE} state_t;

   state_t        state_q, state_d;
   logic [31:0]   lfsr_q, lfsr_d;
   logic [7:0]    vec_q, vec_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0]    fail_q, fail_d;
   logic [7:0]    ffi_q, ffi_d;
   logic          ffe_q, ffe_d;
   logic          pass_q, pass_d;
   logic          done_q, done_d;
   logic          active_q, active_d;
   logic [7:0]    x1_q, x1_d, x2_q, x2_d, v_q, v_d, t_q, t_d, c_q, c_d;
   logic          sel_q, sel_d;

   logic [7:0]    l_x1, l_x2, l_v, l_t;
   logic [15:0]   exp_a, exp_b, prod_vt;
   logic          mis;

   assign l_x1    = lfsr_q[7:0];
   assign l_x2    = lfsr_q[15:8];
   assign l_v     = lfsr_q[23:16];
   assign l_t     = lfsr_q[31:24];
   assign prod_vt = {8'h0, l_v} * {8'h0, l_t};
   assign exp_a   = ({8'h0, l_x1} * {8'h0, l_x2}) + prod_vt;
   assign exp_b   = prod_vt + {8'h0, 8'(l_x1 + l_x2)};

   always_comb begin
      state_d  = state_q;
      lfsr_d   = lfsr_q;
      vec_d    = vec_q;
      cnt_d    = cnt_q;
      fail_d   = fail_q;
      ffi_d    = ffi_q;
      ffe_d    = ffe_q;
      pass_d   = pass_q;
      mis      = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_bist && !abort) begin
               state_d = APPLY_A;
               lfsr_d  = SEED;
               vec_d   = 8'h0;
               cnt_d   = '0;
               fail_d  = 8'h0;
               ffi_d   = 8'h0;
               ffe_d   = 1'b0;
            end
         end
         APPLY_A, APPLY_B: begin
            if (abort) begin
               state_d = IDLE;
               pass_d  = 1'b0;
            end else if (cnt_q != CNT_LAST) begin
               cnt_d = cnt_q + 1'b1;
            end else begin
               cnt_d = '0;
               mis   = (state_q == APPLY_A) ? (result_a != exp_a) : (result_b != exp_b);
               if (mis) begin
                  if (fail_q != 8'hFF) fail_d = fail_q + 8'h1;
                  if (fail_q == 8'h0) begin
                     ffi_d = vec_q;
                     ffe_d = (state_q == APPLY_B);
                  end
               end
               if (mis && STOP_ON_FAIL) begin
                  state_d = DONE;
               end else if (state_q == APPLY_A) begin
                  state_d = APPLY_B;
               end else if (vec_q == VEC_LAST) begin
                  state_d = DONE;
               end else begin
                  state_d = APPLY_A;
                  lfsr_d  = (lfsr_q >> 1) ^ (lfsr_q[0] ? POLY : 32'h0);
                  vec_d   = vec_q + 8'h1;
               end
               // Pass verdict must include a mismatch counted on this same edge.
               if (state_d == DONE) pass_d = (fail_d == 8'h0);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      active_d = (state_d == APPLY_A) || (state_d == APPLY_B);
      done_d   = (state_d == DONE);
      if (active_d) begin
         x1_d  = lfsr_d[7:0];
         x2_d  = lfsr_d[15:8];
         v_d   = lfsr_d[23:16];
         t_d   = lfsr_d[31:24];
         c_d   = lfsr_d[7:0] + lfsr_d[15:8];
         sel_d = (state_d == APPLY_B);
      end else if (done_d) begin
         x1_d  = x1_q;
         x2_d  = x2_q;
         v_d   = v_q;
         t_d   = t_q;
         c_d   = c_q;
         sel_d = sel_q;
      end else begin
         x1_d  = 8'h0;
         x2_d  = 8'h0;
         v_d   = 8'h0;
         t_d   = 8'h0;
         c_d   = 8'h0;
         sel_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= IDLE;
         lfsr_q   <= SEED;
         vec_q    <= 8'h0;
         cnt_q    <= '0;
         fail_q   <= 8'h0;
         ffi_q    <= 8'h0;
         ffe_q    <= 1'b0;
         pass_q   <= 1'b0;
         done_q   <= 1'b0;
         active_q <= 1'b0;
         x1_q     <= 8'h0;
         x2_q     <= 8'h0;
         v_q      <= 8'h0;
         t_q      <= 8'h0;
         c_q      <= 8'h0;
         sel_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         lfsr_q   <= lfsr_d;
         vec_q    <= vec_d;
         cnt_q    <= cnt_d;
         fail_q   <= fail_d;
         ffi_q    <= ffi_d;
         ffe_q    <= ffe_d;
         pass_q   <= pass_d;
         done_q   <= done_d;
         active_q <= active_d;
         x1_q     <= x1_d;
         x2_q     <= x2_d;
         v_q      <= v_d;
         t_q      <= t_d;
         c_q      <= c_d;
         sel_q    <= sel_d;
      end
   end

   assign x1_test        = x1_q;
   assign x2_test        = x2_q;
   assign v_test         = v_q;
   assign t_test         = t_q;
   assign c_test         = c_q;
   assign sel_eq_test    = sel_q;
   assign bist_active    = active_q;
   assign bist_done      = done_q;
   assign bist_pass      = pass_q;
   assign fail_cnt       = fail_q;
   assign first_fail_idx = ffi_q;
   assign first_fail_eq  = ffe_q;
endmodule

// File: tb/tb_bist_seq.sv
// Bench for bist_seq: acts as the equation unit and predicts every BIST output from a run-level model.
module tb_bist_seq;
   localparam int NUM_VEC = 4;
   localparam int SETTLE  = 4;
   localparam logic [31:0] SEED = 32'h05040303;

   logic        clk;
   logic        rst;
   logic        start_r [2];
   logic        abort_r [2];
   logic [15:0] ra_r [2];
   logic [15:0] rb_r [2];
   logic [7:0]  x1_w [2];
   logic [7:0]  x2_w [2];
   logic [7:0]  v_w [2];
   logic [7:0]  t_w [2];
   logic [7:0]  c_w [2];
   logic        sel_w [2];
   logic        act_w [2];
   logic        done_w [2];
   logic        pass_w [2];
   logic [7:0]  fail_w [2];
   logic [7:0]  ffi_w [2];
   logic        ffe_w [2];

   int checks = 0;
   int errors = 0;
   logic [31:0] vecs [NUM_VEC];

   bist_seq #(.NUM_VEC(NUM_VEC), .SETTLE(SETTLE), .LFSR_SEED(SEED), .STOP_ON_FAIL(1'b0)) u_dut0 (
      .clk(clk), .rst(rst), .start_bist(start_r[0]), .abort(abort_r[0]),
      .result_a(ra_r[0]), .result_b(rb_r[0]),
      .x1_test(x1_w[0]), .x2_test(x2_w[0]), .v_test(v_w[0]), .t_test(t_w[0]), .c_test(c_w[0]),
      .sel_eq_test(sel_w[0]), .bist_active(act_w[0]), .bist_done(done_w[0]), .bist_pass(pass_w[0]),
      .fail_cnt(fail_w[0]), .first_fail_idx(ffi_w[0]), .first_fail_eq(ffe_w[0]));

   bist_seq #(.NUM_VEC(NUM_VEC), .SETTLE(SETTLE), .LFSR_SEED(SEED), .STOP_ON_FAIL(1'b1)) u_dut1 (
      .clk(clk), .rst(rst), .start_bist(start_r[1]), .abort(abort_r[1]),
      .result_a(ra_r[1]), .result_b(rb_r[1]),
      .x1_test(x1_w[1]), .x2_test(x2_w[1]), .v_test(v_w[1]), .t_test(t_w[1]), .c_test(c_w[1]),
      .sel_eq_test(sel_w[1]), .bist_active(act_w[1]), .bist_done(done_w[1]), .bist_pass(pass_w[1]),
      .fail_cnt(fail_w[1]), .first_fail_idx(ffi_w[1]), .first_fail_eq(ffe_w[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_quiet(input int u, input string tag);
      chk({tag, "_x1"}, 32'(x1_w[u]), 0);
      chk({tag, "_x2"}, 32'(x2_w[u]), 0);
      chk({tag, "_v"}, 32'(v_w[u]), 0);
      chk({tag, "_t"}, 32'(t_w[u]), 0);
      chk({tag, "_c"}, 32'(c_w[u]), 0);
      chk({tag, "_sel"}, 32'(sel_w[u]), 0);
      chk({tag, "_active"}, 32'(act_w[u]), 0);
      chk({tag, "_done"}, 32'(done_w[u]), 0);
   endtask

   task automatic chk_ops(input int u, input string tag, input logic [31:0] l, input int eq);
      int a, b;
      a = int'(l[7:0]);
      b = int'(l[15:8]);
      chk({tag, "_x1"}, 32'(x1_w[u]), 32'(a));
      chk({tag, "_x2"}, 32'(x2_w[u]), 32'(b));
      chk({tag, "_v"}, 32'(v_w[u]), 32'(l[23:16]));
      chk({tag, "_t"}, 32'(t_w[u]), 32'(l[31:24]));
      chk({tag, "_c"}, 32'(c_w[u]), 32'((a + b) % 256));
      chk({tag, "_sel"}, 32'(sel_w[u]), 32'(eq));
   endtask

   // One run from a start pulse; returns early after an abort or reset at cycle abort_k / rst_k.
   task automatic run(input int u, input bit sof, input int bad_vec, input int bad_eq,
                      input bit all_b_bad, input int abort_k, input int rst_k, input int start_k);
      int k, vec, eq, fc, ffi, ffe, x1, x2, v, t, ea, eb;
      bit fin, mis, sample;
      logic [31:0] l;
      k = 0; fc = 0; ffi = 0; ffe = 0; fin = 0; vec = 0; eq = 0; l = vecs[0];
      start_r[u] = 1'b1;
      @(posedge clk); #1;
      start_r[u] = 1'b0;
      while (!fin) begin
         vec = k / (2 * SETTLE);
         eq  = (k / SETTLE) % 2;
         l   = vecs[vec];
         x1 = int'(l[7:0]); x2 = int'(l[15:8]); v = int'(l[23:16]); t = int'(l[31:24]);
         ea = (x1 * x2 + v * t) % 65536;
         eb = (v * t + (x1 + x2) % 256) % 65536;
         if (k == 0) begin
            chk("vec0_res_a", 32'(int'(x1_w[u]) * int'(x2_w[u]) + int'(v_w[u]) * int'(t_w[u])), 29);
            chk("vec0_res_b", 32'(int'(v_w[u]) * int'(t_w[u]) + int'(c_w[u])), 26);
         end
         chk("run_active", 32'(act_w[u]), 1);
         chk("run_done", 32'(done_w[u]), 0);
         chk_ops(u, "run", l, eq);
         ra_r[u] = 16'($urandom);
         rb_r[u] = 16'($urandom);
         sample = ((k % SETTLE) == SETTLE - 1);
         mis = 1'b0;
         if (sample && eq == 0) begin
            mis = (vec == bad_vec && bad_eq == 0);
            ra_r[u] = 16'(ea + (mis ? 1 : 0));
         end else if (sample) begin
            mis = all_b_bad || (vec == bad_vec && bad_eq == 1);
            rb_r[u] = 16'(eb) ^ (mis ? 16'h0100 : 16'h0);
         end
         if (k == start_k) start_r[u] = 1'b1;
         if (k == abort_k) abort_r[u] = 1'b1;
         if (k == rst_k) rst = 1'b0;
         @(posedge clk); #1;
         start_r[u] = 1'b0;
         if (k == abort_k) begin
            abort_r[u] = 1'b0;
            chk_quiet(u, "abort");
            chk("abort_pass", 32'(pass_w[u]), 0);
            chk("abort_fail_cnt", 32'(fail_w[u]), 32'(fc));
            @(posedge clk); #1;
            chk("abort_no_done", 32'(done_w[u]), 0);
            return;
         end
         if (k == rst_k) begin
            rst = 1'b1;
            chk_quiet(u, "reset");
            chk("reset_pass", 32'(pass_w[u]), 0);
            chk("reset_fail_cnt", 32'(fail_w[u]), 0);
            chk("reset_ffi", 32'(ffi_w[u]), 0);
            chk("reset_ffe", 32'(ffe_w[u]), 0);
            return;
         end
         if (sample && mis) begin
            if (fc == 0) begin ffi = vec; ffe = eq; end
            if (fc < 255) fc++;
         end
         if (sample && ((sof && mis) || (eq == 1 && vec == NUM_VEC - 1))) fin = 1'b1;
         k++;
      end
      chk("done_pulse", 32'(done_w[u]), 1);
      chk("done_active", 32'(act_w[u]), 0);
      chk("done_cycles", 32'(k), sof && fc > 0 ? 32'(k) : 32'(2 * SETTLE * NUM_VEC));
      chk("done_pass", 32'(pass_w[u]), 32'(fc == 0));
      chk("done_fail_cnt", 32'(fail_w[u]), 32'(fc));
      chk("done_ffi", 32'(ffi_w[u]), 32'(ffi));
      chk("done_ffe", 32'(ffe_w[u]), 32'(ffe));
      chk_ops(u, "done_hold", l, eq);
      @(posedge clk); #1;
      chk_quiet(u, "post_done");
      chk("post_done_pass", 32'(pass_w[u]), 32'(fc == 0));
   endtask

   initial begin
      int bv, be, t0, dcyc;
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         start_r[i] = 1'b0; abort_r[i] = 1'b0; ra_r[i] = 16'h0; rb_r[i] = 16'h0;
      end
      vecs[0] = SEED;
      for (int i = 1; i < NUM_VEC; i++)
         vecs[i] = (vecs[i-1] >> 1) ^ (vecs[i-1][0] ? 32'h80200003 : 32'h0);
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         chk_quiet(i, "init");
         chk("init_pass", 32'(pass_w[i]), 0);
         chk("init_fail_cnt", 32'(fail_w[i]), 0);
         chk("init_ffi", 32'(ffi_w[i]), 0);
         chk("init_ffe", 32'(ffe_w[i]), 0);
      end
      rst = 1'b1;
      @(posedge clk); #1;

      // Clean run, with a stray start pulse mid-run that must be ignored.
      run(0, 1'b0, -1, -1, 1'b0, -1, -1, 5);
      repeat (3) begin
         @(posedge clk); #1;
         chk("no_restart_active", 32'(act_w[0]), 0);
         chk("no_extra_done", 32'(done_w[0]), 0);
      end

      run(0, 1'b0, 2, 0, 1'b0, -1, -1, -1);

      for (int r = 0; r < 3; r++) begin
         bv = int'($urandom_range(0, NUM_VEC - 1));
         be = int'($urandom_range(0, 1));
         run(0, 1'b0, bv, be, 1'b0, -1, -1, -1);
      end

      // Stop-on-first-fail instance with the battery result always wrong.
      t0 = 0;
      run(1, 1'b1, -1, -1, 1'b1, -1, -1, -1);

      run(0, 1'b0, -1, -1, 1'b0, 10, -1, -1);
      run(0, 1'b0, -1, -1, 1'b0, -1, -1, -1);

      run(0, 1'b0, 1, 1, 1'b0, -1, 29, -1);
      @(posedge clk); #1;
      run(0, 1'b0, -1, -1, 1'b0, -1, -1, -1);

      // Start and abort together in IDLE: abort wins.
      start_r[0] = 1'b1;
      abort_r[0] = 1'b1;
      @(posedge clk); #1;
      start_r[0] = 1'b0;
      abort_r[0] = 1'b0;
      dcyc = 0;
      for (int i = 0; i < 2 * SETTLE * NUM_VEC + 4; i++) begin
         if (act_w[0] === 1'b1 || done_w[0] === 1'b1) dcyc++;
         @(posedge clk); #1;
      end
      chk("start_abort_idle", 32'(dcyc), 32'(t0));
      chk("start_abort_pass", 32'(pass_w[0]), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
